// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types for the core clock-enable controller.
// Command opcodes and controller states.
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_SET_DIV = 2'b00,
    OP_RUN     = 2'b01,
    OP_HALT    = 2'b10,
    OP_STEP    = 2'b11
  } clk_op_t;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_STEPPING = 2'b10
  } clk_state_t;

endpackage

// File: rtl/cpu_clk_ctrl_ce_prescaler.sv
// Divided tick generator with a divisor that only changes
// on a period boundary, so no runt or stretched CE period.
module cpu_clk_ctrl_ce_prescaler #(
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load_div,
  input  logic [DIV_W-1:0] i_new_div,
  output logic             o_tick,
  output logic             o_pending
);

  logic [DIV_W-1:0] r_ctr;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pend;
  logic             r_pending;
  logic [DIV_W-1:0] w_eff;
  logic             w_bound;

  assign w_eff = (r_div == '0) ? DIV_W'(1) : r_div;
  assign o_tick = i_en && (r_ctr == (w_eff - DIV_W'(1)));
  assign o_pending = r_pending;

  // Idle or at a tick the period restarts, so a new divisor is safe.
  assign w_bound = o_tick || !i_en || i_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ctr     <= '0;
      r_div     <= DIV_W'(DIV_RST);
      r_pend    <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_bound) begin
        r_ctr <= '0;
      end else begin
        r_ctr <= r_ctr + DIV_W'(1);
      end
      if (i_load_div) begin
        if (!i_en || o_tick) begin
          r_div <= i_new_div;
        end else begin
          r_pend    <= i_new_div;
          r_pending <= 1'b1;
        end
      end else if (r_pending && w_bound) begin
        r_div     <= r_pend;
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Run/halt/single-step controller driving the core clock enable.
// Holds the FSM, step counter, command handshake and CE counter.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int CNT_W   = 32,
  parameter int DIV_RST = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [DIV_W-1:0] i_cmd_arg,
  input  logic             i_halt_in,
  output logic             o_ce,
  output logic             o_step_done,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_ticks
);

  clk_state_t       r_state;
  clk_state_t       w_next;
  logic [DIV_W-1:0] r_step;
  logic [DIV_W-1:0] w_step_nxt;
  logic [DIV_W-1:0] w_arg_n;
  logic [DIV_W-1:0] w_left;
  logic             r_ce;
  logic             r_fin;
  logic             r_done;
  logic [CNT_W-1:0] r_ticks;
  clk_op_t          w_op;
  logic             w_acc;
  logic             w_run;
  logic             w_halt;
  logic             w_step;
  logic             w_set;
  logic             w_start;
  logic             w_en;
  logic             w_clr;
  logic             w_tick;
  logic             w_pending;
  logic             w_fin;

  assign w_op   = clk_op_t'(i_cmd_op);
  assign w_acc  = i_cmd_valid && !w_pending;
  assign w_run  = w_acc && (w_op == OP_RUN);
  assign w_halt = w_acc && (w_op == OP_HALT);
  assign w_step = w_acc && (w_op == OP_STEP);
  assign w_set  = w_acc && (w_op == OP_SET_DIV);

  assign w_arg_n = (i_cmd_arg == '0) ? DIV_W'(1) : i_cmd_arg;

  // The prescaler counts in the accept cycle so CE lands div cycles later.
  assign w_start = (r_state == ST_HALTED) && !i_halt_in
                   && (w_run || w_step);
  assign w_en    = (r_state != ST_HALTED) || w_start;
  assign w_clr   = (r_state != ST_HALTED) && (i_halt_in || w_halt);
  assign w_left  = (r_state == ST_HALTED) ? w_arg_n : r_step;

  cpu_clk_ctrl_ce_prescaler #(
    .DIV_W   (DIV_W),
    .DIV_RST (DIV_RST)
  ) u_presc (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (w_en),
    .i_clr      (w_clr),
    .i_load_div (w_set),
    .i_new_div  (i_cmd_arg),
    .o_tick     (w_tick),
    .o_pending  (w_pending)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_HALTED;
      r_step  <= '0;
    end else begin
      r_state <= w_next;
      r_step  <= w_step_nxt;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_step_nxt = r_step;
    w_fin      = 1'b0;
    unique case (r_state)
      ST_HALTED: begin
        if (w_start) begin
          w_next = w_run ? ST_RUNNING : ST_STEPPING;
        end
      end
      ST_RUNNING: begin
        if (i_halt_in || w_halt) begin
          w_next = ST_HALTED;
        end
      end
      ST_STEPPING: begin
        if (i_halt_in || w_halt) begin
          w_next = ST_HALTED;
        end else if (w_run) begin
          w_next = ST_RUNNING;
        end
      end
      default: w_next = ST_HALTED;
    endcase
    if (w_next == ST_STEPPING) begin
      if (w_tick) begin
        w_step_nxt = w_left - DIV_W'(1);
        if (w_left == DIV_W'(1)) begin
          w_next = ST_HALTED;
          w_fin  = 1'b1;
        end
      end else begin
        w_step_nxt = w_left;
      end
    end
    if (w_next != ST_STEPPING) begin
      w_step_nxt = '0;
    end
  end

  always_comb begin
    o_state     = r_state;
    o_cmd_ready = !w_pending;
    o_ce        = r_ce;
    o_step_done = r_done;
    o_ticks     = r_ticks;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ce    <= 1'b0;
      r_fin   <= 1'b0;
      r_done  <= 1'b0;
      r_ticks <= '0;
    end else begin
      r_ce   <= w_tick;
      r_fin  <= w_fin;
      r_done <= r_fin;
      if (w_tick) begin
        r_ticks <= r_ticks + CNT_W'(1);
      end
    end
  end

endmodule
